// File: rtl/sca_mux_arb.sv
// ============================================================================
// Module      : sca_mux_arb
// Description : Two-source arbitrated mux into a single-entry output register
//               with valid/ready handshakes.
//               Optional macro SCA_MUX_ARB_RR_EN selects round-robin
//               contention; the default build grants A on contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sca_mux_arb #(
    parameter int SIZE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] a,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [SIZE-1:0] b,
    input  logic            b_valid,
    output logic            b_ready,
    output logic [SIZE-1:0] out,
    output logic            sel,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SIZE-1:0] r_out;
    logic            r_sel;
    logic            r_last;

    logic            w_take;
    logic            w_pick_b;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_load;

    assign w_take = (r_state == ST_EMPTY) | out_ready;

`ifdef SCA_MUX_ARB_RR_EN
    // On contention, B wins only if A was the last source served.
    assign w_pick_b = ~r_last;
`else
    assign w_pick_b = 1'b0;
`endif

    assign w_grant_b = b_valid & (~a_valid | w_pick_b);
    assign w_grant_a = a_valid & ~w_grant_b;
    assign w_load    = w_take & (w_grant_a | w_grant_b);

    // Readiness is gated by reset so that no handshake completes while held.
    assign a_ready   = rst_n & w_take & w_grant_a;
    assign b_ready   = rst_n & w_take & w_grant_b;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_load) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_out  <= w_grant_b ? b : a;
                r_sel  <= w_grant_b;
                r_last <= w_grant_b;
            end
        end
    end

    assign out       = r_out;
    assign sel       = r_sel;
    assign out_valid = (r_state == ST_FULL);

endmodule

`default_nettype wire

// File: doc/sca_mux_arb.md
SCA_MUX_ARB -- requirements
Module: sca_mux_arb

Interface
- REQ-001 SHALL provide parameter: SIZE, 1, data width in bits of A, B and OUT.
- REQ-002 SHALL provide port: CLK  input  1  single clock; all state updates on rising edge.
- REQ-003 SHALL provide port: RST_N  input  1  reset, asynchronous, active-low.
- REQ-004 SHALL provide port: A  input  SIZE  source-A data word.
- REQ-005 SHALL provide port: A_VALID  input  1  source-A word present.
- REQ-006 SHALL provide port: A_READY  output  1  source-A word accepted this cycle.
- REQ-007 SHALL provide port: B  input  SIZE  source-B data word.
- REQ-008 SHALL provide port: B_VALID  input  1  source-B word present.
- REQ-009 SHALL provide port: B_READY  output  1  source-B word accepted this cycle.
- REQ-010 SHALL provide port: OUT  output  SIZE  registered selected word.
- REQ-011 SHALL provide port: SEL  output  1  origin of the word in OUT; 0 = A, 1 = B (same encoding as the sca_mux select).
- REQ-012 SHALL provide port: OUT_VALID  output  1  OUT holds an undelivered word.
- REQ-013 SHALL provide port: OUT_READY  input  1  consumer accepts OUT this cycle.

Function
- REQ-014 SHALL contain a single-entry output register with two states: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
- REQ-015 SHALL assert internal signal "take" when OUT_VALID=0, or when OUT_VALID=1 and OUT_READY=1 in the same cycle.
- REQ-016 SHALL compute the grant combinationally from A_VALID, B_VALID and register LAST (the last granted source).
- REQ-017 SHALL drive A_READY=take & grantA and B_READY=take & grantB; at most one of them is high in any cycle.
- REQ-018 SHALL leave both READY signals low when neither VALID is high.
- REQ-019 SHALL, when one source is granted with take=1, load its word into OUT, load SEL with its index, set OUT_VALID=1, and update LAST, all at the next edge; latency is 1 cycle.
- REQ-020 SHALL clear OUT_VALID when OUT_READY=1 and no source is granted (FULL->EMPTY).
- REQ-021 SHALL remain FULL when OUT_READY=1 and a source is granted in the same cycle; the new word replaces the old one with no bubble, giving 1 word per cycle sustained.
- REQ-022 SHALL hold OUT and SEL stable while OUT_VALID=1 and OUT_READY=0.
- REQ-023 SHALL treat OUT_READY as don't-care in state EMPTY.
- REQ-024 SHALL not require a source to wait for its own READY before asserting VALID; data are sampled only on the handshake cycle.

Reset
- REQ-025 SHALL, on RST_N low, asynchronously force OUT=0, SEL=0, OUT_VALID=0 and LAST=1 (B), so that A wins the first contention.
- REQ-026 SHALL drop any word held in OUT when reset is asserted mid-transfer; after release, no word is replayed.
- REQ-027 SHALL hold A_READY=B_READY=0 while RST_N is low.

Configuration
- REQ-028 SHALL use macro SCA_MUX_ARB_RR_EN to select the contention policy.
- REQ-029 SHALL, when SCA_MUX_ARB_RR_EN is defined and both sources are valid, grant the source not equal to LAST (round-robin).
- REQ-030 SHALL, when SCA_MUX_ARB_RR_EN is undefined and both sources are valid, always grant A (fixed priority); LAST is still updated but does not affect the grant.

Verification (SIZE=6)
- REQ-031 SHALL cover: A=6'b10_0100 with A_VALID=1, B_VALID=0, OUT_READY=1 -> next cycle OUT=6'b10_0100, SEL=0, OUT_VALID=1.
- REQ-032 SHALL cover: both valid continuously, A=6'b01_0111, B=6'b10_1001, OUT_READY=1, RR_EN defined -> SEL sequence 0,1,0,1 with OUT alternating between the two words; with RR_EN undefined -> SEL stays 0.
- REQ-033 SHALL cover: OUT_VALID=1 with OUT_READY=0 for 3 cycles while B_VALID=1 -> B_READY=0 and OUT/SEL unchanged; when OUT_READY=1, B's word appears the next cycle.
- REQ-034 SHALL cover: OUT_VALID=1, OUT_READY=1, no source valid -> OUT_VALID=0 next cycle and OUT holds its last value.
- REQ-035 SHALL cover: RST_N pulsed low mid-stream while OUT_VALID=1 -> OUT_VALID, OUT and SEL go to 0 immediately (no clock needed); after release with both sources valid, the first grant is A.
